// File: rtl/decoder_pkg.sv
// Shared decoder definitions: opcode encodings, stage FSM states and the legal-opcode test.
package decoder_pkg;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_LI  = 5'b00001;
  localparam logic [4:0] OP_LD  = 5'b00010;
  localparam logic [4:0] OP_ST  = 5'b00011;
  localparam logic [4:0] OP_INC = 5'b10001;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  // Callers pass the opcode zero-extended to 32 bits so any OPC_W >= 5 works.
  function automatic logic is_legal_op(input logic [31:0] op);
    return (op == 32'(OP_NOP)) || (op == 32'(OP_LI)) || (op == 32'(OP_LD)) ||
           (op == 32'(OP_ST))  || (op == 32'(OP_INC));
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decode: instr -> opcode, operand field, flags, extended imm.
// Zero latency, no handshake; shared with the trace/disassembly monitor.
module decode_comb
  import decoder_pkg::*;
#(
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned OPC_W    = 5,
  parameter int unsigned FIELD_W  = INSTR_W - OPC_W,
  parameter int unsigned IMM_W    = 8,
  parameter bit          SIGN_EXT = 1'b0
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [FIELD_W-1:0] field_o,
  output logic [IMM_W-1:0]   imm_o,
  output logic               is_alu_op_o,
  output logic               is_mem_op_o,
  output logic               mem_rw_o,
  output logic               illegal_o
);

  logic             legal;
  logic             has_imm;
  logic [IMM_W-1:0] imm_ext;

  assign opcode_o = instr_i[INSTR_W-1 -: OPC_W];
  assign field_o  = instr_i[FIELD_W-1:0];
  assign legal    = is_legal_op(32'(opcode_o));
  assign has_imm  = (opcode_o == OPC_W'(OP_LI)) || (opcode_o == OPC_W'(OP_INC));

  always_comb begin
    imm_ext                = '0;
    imm_ext[FIELD_W-1:0]   = field_o;
    for (int i = FIELD_W; i < IMM_W; i++) begin
      imm_ext[i] = SIGN_EXT && field_o[FIELD_W-1];
    end
  end

  assign illegal_o   = !legal;
  assign is_alu_op_o = legal && opcode_o[OPC_W-1];
  assign is_mem_op_o = (opcode_o == OPC_W'(OP_LD)) || (opcode_o == OPC_W'(OP_ST));
  assign mem_rw_o    = is_mem_op_o && opcode_o[0];
  assign imm_o       = has_imm ? imm_ext : '0;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: 1-cycle accept-to-valid, 1 instr/cycle; fields held until out_ready.
// Memory ops stall input until mem_done or MEM_TIMEOUT, then retire with an increment_pc pulse.
module decode_stage
  import decoder_pkg::*;
#(
  parameter int unsigned INSTR_W     = 8,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned FIELD_W     = INSTR_W - OPC_W,
  parameter int unsigned IMM_W       = 8,
  parameter bit          SIGN_EXT    = 1'b0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [FIELD_W-1:0] register,
  output logic [IMM_W-1:0]   imm,
  output logic               is_alu_op,
  output logic               is_mem_op,
  output logic               mem_rw,
  output logic               illegal,
  input  logic               mem_done,
  output logic               increment_pc,
  output logic               mem_err
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OPC_W-1:0]   opcode_q;
  logic [FIELD_W-1:0] field_q;
  logic [IMM_W-1:0]   imm_q;
  logic               alu_q, mem_q, rw_q, illegal_q;

  logic [OPC_W-1:0]   dec_opcode;
  logic [FIELD_W-1:0] dec_field;
  logic [IMM_W-1:0]   dec_imm;
  logic               dec_alu, dec_mem, dec_rw, dec_illegal;

  logic load, in_rdy, out_vld, inc_pc, err;

  decode_comb #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W),
    .FIELD_W (FIELD_W),
    .IMM_W   (IMM_W),
    .SIGN_EXT(SIGN_EXT)
  ) u_decode_comb (
    .instr_i    (instr),
    .opcode_o   (dec_opcode),
    .field_o    (dec_field),
    .imm_o      (dec_imm),
    .is_alu_op_o(dec_alu),
    .is_mem_op_o(dec_mem),
    .mem_rw_o   (dec_rw),
    .illegal_o  (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    inc_pc  = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        in_rdy = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        out_vld = 1'b1;
        in_rdy  = out_ready && !mem_q;
        if (out_ready) begin
          if (mem_q) begin
            state_d = ST_MEM_WAIT;
            cnt_d   = '0;
          end else begin
            inc_pc = 1'b1;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A late mem_done coinciding with the timeout still counts as success.
        if (mem_done) begin
          inc_pc  = 1'b1;
          state_d = ST_EMPTY;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          inc_pc  = 1'b1;
          err     = 1'b1;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= '0;
      opcode_q  <= '0;
      field_q   <= '0;
      imm_q     <= '0;
      alu_q     <= 1'b0;
      mem_q     <= 1'b0;
      rw_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        opcode_q  <= dec_opcode;
        field_q   <= dec_field;
        imm_q     <= dec_imm;
        alu_q     <= dec_alu;
        mem_q     <= dec_mem;
        rw_q      <= dec_rw;
        illegal_q <= dec_illegal;
      end
    end
  end

  // Handshake outputs are forced low while reset is asserted.
  assign in_ready     = reset && in_rdy;
  assign out_valid    = reset && out_vld;
  assign increment_pc = reset && inc_pc;
  assign mem_err      = reset && err;

  assign opcode    = opcode_q;
  assign register  = field_q;
  assign imm       = imm_q;
  assign is_alu_op = alu_q;
  assign is_mem_op = mem_q;
  assign mem_rw    = rw_q;
  assign illegal   = illegal_q;

endmodule
